decode_skid_stage: RTL
======================

DECODE_SKID_STAGE -- requirements
Module: decode_skid_stage

Interface
REQ-001 SHALL provide parameter: NOP_INSTR, 32'h00000013, instruction word loaded into the main register on reset and flush.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port: instrF  input  32  fetched instruction word.
REQ-005 SHALL provide port: pcF  input  32  PC of instrF.
REQ-006 SHALL provide port: validF  input  1  instrF/pcF valid this cycle.
REQ-007 SHALL provide port: readyF  output  1  stage can accept a beat this cycle.
REQ-008 SHALL provide port: flushD  input  1  discard all held and incoming beats (branch redirect).
REQ-009 SHALL provide port: readyE  input  1  downstream (immediate extender / execute) accepts the current beat.
REQ-010 SHALL provide port: validD  output  1  output beat valid.
REQ-011 SHALL provide port: immSrcD  output  25  instrD[31:7], raw immediate field feeding the extender.
REQ-012 SHALL provide port: immCntrlD  output  3  immediate type code for the extender.
REQ-013 SHALL provide ports: rs1D / rs2D / rdD  output  5 each  instrD[19:15] / [24:20] / [11:7].
REQ-014 SHALL provide port: pcD  output  32  PC of the output beat.
REQ-015 SHALL provide port: illegalD  output  1  output beat has an unrecognised opcode.

Function
REQ-016 SHALL hold a main register and a skid register, each storing instr, pc, decoded immCntrl and illegal; state is EMPTY (none valid), ONE (main valid), FULL (both valid).
REQ-017 SHALL drive readyF = 1 in EMPTY and ONE and 0 in FULL, from registered state only (no combinational path from readyE or validF).
REQ-018 SHALL define inFire = validF & readyF and outFire = validD & readyE; validD = 1 in ONE and FULL.
REQ-019 SHALL transition: EMPTY+inFire -> ONE (main <- input); ONE+inFire+outFire -> ONE (main <- input); ONE+inFire+!outFire -> FULL (skid <- input); ONE+!inFire+outFire -> EMPTY; FULL+outFire -> ONE (main <- skid); otherwise hold.
REQ-020 SHALL present all outputs combinationally from the main register only; latency input-to-output is exactly 1 cycle when not stalled.
REQ-021 SHALL keep main register contents and outputs stable while validD=1 and readyE=0.
REQ-022 SHALL decode immCntrl from instr[6:0] when a beat is captured (main or skid): 0010011 with funct3 001/101 -> 3'b001; 0010011 other, 0000011, 1100111 -> 3'b010; 0100011 -> 3'b011; 1100011 -> 3'b100; 0110111, 0010111 -> 3'b101; 1101111 -> 3'b110; 0110011 -> 3'b000.
REQ-023 SHALL set illegal=1 and immCntrl=3'b000 for any other opcode or instr[1:0] != 2'b11; illegal beats still flow through the handshake normally.
REQ-024 SHALL, on flushD=1, go to EMPTY next cycle, load main with NOP_INSTR / pc 0 / immCntrl 3'b010 / illegal 0, and discard any same-cycle input beat; flush has priority over all transitions.
REQ-025 SHALL never drop or duplicate a beat: every inFire beat appears exactly once as an outFire beat, in order, unless flushed.
REQ-026 SHALL treat readyE while validD=0 as don't-care (no state change).

Reset
REQ-027 SHALL, when rst=1 at a clock edge, enter EMPTY, load main with NOP_INSTR, pc 32'h0, immCntrl 3'b010, illegal 0, clear skid valid; rst has priority over flushD.
REQ-028 SHALL, after reset, output validD=0, readyF=1, immSrcD=25'h0000000 upper bits of NOP (NOP_INSTR[31:7]), rdD=0, rs1D=0.
REQ-029 SHALL behave identically for reset asserted mid-stream (FULL state) -- all held beats discarded.

Verification
REQ-030 SHALL cover: reset, then validF=1 instrF=32'h00500093 pcF=32'h100, readyE=1 -> next cycle validD=1, immCntrlD=3'b010, rdD=1, immSrcD=instr[31:7], pcD=32'h100.
REQ-031 SHALL cover: readyE=0 for 2 cycles with 3 back-to-back inputs -> state FULL, readyF=0 after 2nd accept, 3rd beat held off; readyE=1 -> beats 1,2,3 out in order, no loss.
REQ-032 SHALL cover: flushD=1 while FULL and validF=1 -> next cycle validD=0, readyF=1, outputs equal NOP fields; flushed beats never appear.
REQ-033 SHALL cover: opcode sweep 32'h00101093 (slli) -> 3'b001; 32'h00112023 (sw) -> 3'b011; 32'h00000063 (beq) -> 3'b100; 32'h000002b7 (lui) -> 3'b101; 32'h0000006f (jal) -> 3'b110; 32'hFFFFFFFF -> illegalD=1, immCntrlD=3'b000.
REQ-034 SHALL cover: random validF/readyE/flushD for 10k cycles against a reference queue model -> order preserved, no duplicates, readyF never depends combinationally on readyE.

Source files
------------

// File: rtl/decode_skid_stage.sv
// ---------------------------------------------------------------------------
// decode_skid_stage
//
// Decode-side pipeline register with a one-entry skid buffer. Each accepted
// fetch beat is pre-decoded (immediate type code and illegal flag) at capture
// time, so the outputs come straight from the main register with no decode
// logic on the output path.
//
// The occupancy is EMPTY, ONE (main valid) or FULL (main and skid valid).
// readyF depends only on the registered occupancy. Because of that, it never
// has a combinational path from readyE or validF.
//
// Ports
//   clk        clock; every state update happens on the rising edge
//   rst        synchronous, active-high reset
//   instrF     fetched instruction word
//   pcF        PC of instrF
//   validF     instrF/pcF valid this cycle
//   readyF     stage can accept a beat this cycle
//   flushD     discard all held and incoming beats (branch redirect)
//   readyE     downstream accepts the current output beat
//   validD     output beat valid
//   immSrcD    instrD[31:7], raw immediate field for the extender
//   immCntrlD  immediate type code for the extender
//   rs1D       instrD[19:15]
//   rs2D       instrD[24:20]
//   rdD        instrD[11:7]
//   pcD        PC of the output beat
//   illegalD   output beat has an unrecognised opcode
// ---------------------------------------------------------------------------
module decode_skid_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instrF,
   input  logic [31:0] pcF,
   input  logic        validF,
   output logic        readyF,
   input  logic        flushD,
   input  logic        readyE,
   output logic        validD,
   output logic [24:0] immSrcD,
   output logic [2:0]  immCntrlD,
   output logic [4:0]  rs1D,
   output logic [4:0]  rs2D,
   output logic [4:0]  rdD,
   output logic [31:0] pcD,
   output logic        illegalD
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   // The opcode is fully consumed by the capture-time decode. Only
   // instr[31:7] is needed afterwards, so only those bits are stored.
   typedef struct packed {
      logic [24:0] instr_hi;
      logic [31:0] pc;
      logic [2:0]  imm_cntrl;
      logic        illegal;
   } beat_t;

   localparam beat_t NOP_BEAT = {NOP_INSTR[31:7], 32'h0, 3'b010, 1'b0};

   function automatic beat_t decode_beat(input logic [31:0] instr,
                                         input logic [31:0] pc);
      beat_t b;
      b.instr_hi  = instr[31:7];
      b.pc        = pc;
      b.imm_cntrl = 3'b000;
      b.illegal   = 1'b0;
      // Matching all 7 opcode bits also rejects instr[1:0] != 2'b11.
      case (instr[6:0])
         7'b0010011: begin
            // Shift-immediates use the shamt form; other OP-IMM use I-type.
            if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
               b.imm_cntrl = 3'b001;
            else
               b.imm_cntrl = 3'b010;
         end
         7'b0000011, 7'b1100111: b.imm_cntrl = 3'b010;
         7'b0100011:             b.imm_cntrl = 3'b011;
         7'b1100011:             b.imm_cntrl = 3'b100;
         7'b0110111, 7'b0010111: b.imm_cntrl = 3'b101;
         7'b1101111:             b.imm_cntrl = 3'b110;
         7'b0110011:             b.imm_cntrl = 3'b000;
         default:                b.illegal   = 1'b1;
      endcase
      return b;
   endfunction

   state_t state_q;
   beat_t  main_q;
   beat_t  skid_q;
   beat_t  in_beat_d;
   logic   in_fire;
   logic   out_fire;

   assign in_beat_d = decode_beat(instrF, pcF);

   assign readyF   = (state_q != FULL);
   assign validD   = (state_q != EMPTY);
   assign in_fire  = validF & readyF;
   assign out_fire = validD & readyE;

   always_ff @(posedge clk) begin
      // Reset and flush have the same effect, and both override any
      // handshake that happens in the same cycle.
      if (rst || flushD) begin
         state_q <= EMPTY;
         main_q  <= NOP_BEAT;
         skid_q  <= NOP_BEAT;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_q  <= in_beat_d;
                  state_q <= ONE;
               end
            end
            ONE: begin
               case ({in_fire, out_fire})
                  2'b11: main_q <= in_beat_d;
                  2'b10: begin
                     // Downstream stalled: park the new beat behind main.
                     skid_q  <= in_beat_d;
                     state_q <= FULL;
                  end
                  2'b01: state_q <= EMPTY;
                  default: ;
               endcase
            end
            FULL: begin
               // readyF is low here, so the input is never accepted.
               if (out_fire) begin
                  main_q  <= skid_q;
                  state_q <= ONE;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign immSrcD   = main_q.instr_hi;
   assign immCntrlD = main_q.imm_cntrl;
   assign rs1D      = main_q.instr_hi[12:8];   // instr[19:15]
   assign rs2D      = main_q.instr_hi[17:13];  // instr[24:20]
   assign rdD       = main_q.instr_hi[4:0];    // instr[11:7]
   assign pcD       = main_q.pc;
   assign illegalD  = main_q.illegal;

endmodule
